// File: rtl/act_unit_pipe_if.sv
// act_unit_pipe_if: input beat, output beat and their valid/ready handshakes for act_unit_pipe.
// The slave modport is the pipeline side; the master modport is the producer/consumer side.
interface act_unit_pipe_if #(
  parameter int unsigned DATA_WIDTH = 26,
  parameter int unsigned OUT_SIZE   = 14,
  parameter int unsigned LANES      = 16
);
  logic [1:0]                  mode;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH*LANES-1:0] input_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_SIZE*LANES-1:0]   output_data;

  modport slave (
    input  mode, in_valid, input_data, out_ready,
    output in_ready, out_valid, output_data
  );

  modport master (
    output mode, in_valid, input_data, out_ready,
    input  in_ready, out_valid, output_data
  );
endinterface

// File: rtl/act_unit_pipe.sv
// act_unit_pipe: 3-stage per-lane activation (hard-swish, hard-sigmoid, ReLU, ReLU6) with valid/ready flow.
// Define ACT_SAT_CNT_EN to add the sat_count port counting output beats with a saturated lane.
module act_unit_pipe #(
  parameter int unsigned DATA_WIDTH = 26,
  parameter int unsigned FRAC_BITS  = 9,
  parameter int unsigned OUT_SIZE   = 14,
  parameter int unsigned LANES      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
`ifdef ACT_SAT_CNT_EN
  output logic [15:0] sat_count,
`endif
  act_unit_pipe_if.slave bus
);

  localparam int unsigned XW = (DATA_WIDTH > FRAC_BITS + 3) ? DATA_WIDTH : FRAC_BITS + 3;
  localparam int unsigned SW = XW + 1;             // x + 3S, signed
  localparam int unsigned TW = FRAC_BITS + 3;      // t in [0, 6S], unsigned
  localparam int unsigned MW = TW + 15;            // t*10923 + 2^15
  localparam int unsigned HW = MW - 16;            // h after the >>16
  localparam int unsigned PW = DATA_WIDTH + HW + 1;
  localparam int unsigned RW = PW + 1;

  localparam logic signed [SW-1:0] THREE_S  = SW'(3) <<< FRAC_BITS;
  localparam logic signed [SW-1:0] SIX_S    = SW'(6) <<< FRAC_BITS;
  localparam logic signed [RW-1:0] SIX_R    = RW'(6) <<< FRAC_BITS;
  localparam logic signed [RW-1:0] HALF_R   = RW'(1) <<< (FRAC_BITS - 1);
  localparam logic        [MW-1:0] K_RECIP6 = MW'(10923);
  localparam logic        [MW-1:0] K_ROUND  = MW'(32768);
  localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_SIZE+1){1'b0}}, {(OUT_SIZE-1){1'b1}}};
  localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_SIZE+1){1'b1}}, {(OUT_SIZE-1){1'b0}}};

  logic                         v1_q, v2_q, v3_q;
  logic                         ld1, ld2, ld3;
  logic [1:0]                   mode1_q, mode2_q;
  logic signed [DATA_WIDTH-1:0] x1_q [LANES];
  logic        [TW-1:0]         t1_q [LANES];
  logic signed [DATA_WIDTH-1:0] x2_q [LANES];
  logic        [HW-1:0]         h2_q [LANES];
  logic signed [PW-1:0]         prod2_q [LANES];
  logic [OUT_SIZE*LANES-1:0]    out_q;

  logic signed [SW-1:0]         sum_c [LANES];
  logic        [TW-1:0]         t_d [LANES];
  logic        [HW-1:0]         h_d [LANES];
  logic signed [PW-1:0]         prod_d [LANES];
  logic signed [RW-1:0]         sel_c [LANES];
  logic [LANES-1:0]             hi_c, lo_c;
  logic [OUT_SIZE*LANES-1:0]    out_d;

  // A stage loads when it is empty or its successor is loading, so bubbles collapse.
  always_comb begin
    ld3 = en & (~v3_q | bus.out_ready);
    ld2 = en & (~v2_q | ld3);
    ld1 = en & rst & (~v1_q | ld2);
  end

  assign bus.in_ready    = ld1;
  assign bus.out_valid   = v3_q;
  assign bus.output_data = out_q;

  // S1 combinational: t = clamp(x + 3S, 0, 6S)
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      sum_c[k] = SW'($signed(bus.input_data[k*DATA_WIDTH +: DATA_WIDTH])) + THREE_S;
      if (sum_c[k][SW-1])         t_d[k] = '0;
      else if (sum_c[k] > SIX_S)  t_d[k] = TW'(SIX_S);
      else                        t_d[k] = TW'(sum_c[k]);
    end
  end

  // S2 combinational: h = round(t/6) and the hard-swish product x*h
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      h_d[k]    = HW'((MW'(t1_q[k]) * K_RECIP6 + K_ROUND) >> 16);
      prod_d[k] = PW'(x1_q[k]) * PW'($signed({1'b0, h_d[k]}));
    end
  end

  // S3 combinational: round, per-beat mode select, saturate to the output lane range
  always_comb begin
    out_d = '0;
    hi_c  = '0;
    lo_c  = '0;
    for (int k = 0; k < LANES; k++) begin
      sel_c[k] = '0;
      case (mode2_q)
        2'b00:   sel_c[k] = (RW'(prod2_q[k]) + HALF_R) >>> FRAC_BITS;
        2'b01:   sel_c[k] = RW'($signed({1'b0, h2_q[k]}));
        2'b10:   sel_c[k] = x2_q[k][DATA_WIDTH-1] ? '0 : RW'(x2_q[k]);
        default: sel_c[k] = x2_q[k][DATA_WIDTH-1] ? '0 :
                            ((RW'(x2_q[k]) > SIX_R) ? SIX_R : RW'(x2_q[k]));
      endcase
      hi_c[k] = sel_c[k] > OMAX;
      lo_c[k] = sel_c[k] < OMIN;
      if (hi_c[k])      out_d[k*OUT_SIZE +: OUT_SIZE] = OUT_SIZE'(OMAX);
      else if (lo_c[k]) out_d[k*OUT_SIZE +: OUT_SIZE] = OUT_SIZE'(OMIN);
      else              out_d[k*OUT_SIZE +: OUT_SIZE] = OUT_SIZE'(sel_c[k]);
    end
  end

  // Stage registers; payload only moves with a valid beat so stalled data stays put.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      mode1_q <= '0;
      mode2_q <= '0;
      out_q   <= '0;
      for (int k = 0; k < LANES; k++) begin
        x1_q[k]    <= '0;
        t1_q[k]    <= '0;
        x2_q[k]    <= '0;
        h2_q[k]    <= '0;
        prod2_q[k] <= '0;
      end
    end else begin
      if (ld1) begin
        v1_q <= bus.in_valid;
        if (bus.in_valid) begin
          mode1_q <= bus.mode;
          for (int k = 0; k < LANES; k++) begin
            x1_q[k] <= $signed(bus.input_data[k*DATA_WIDTH +: DATA_WIDTH]);
            t1_q[k] <= t_d[k];
          end
        end
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          mode2_q <= mode1_q;
          for (int k = 0; k < LANES; k++) begin
            x2_q[k]    <= x1_q[k];
            h2_q[k]    <= h_d[k];
            prod2_q[k] <= prod_d[k];
          end
        end
      end
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) out_q <= out_d;
      end
    end
  end

`ifdef ACT_SAT_CNT_EN
  logic        sat3_q;
  logic [15:0] sat_cnt_q;

  // Sticky-at-max count of transferred beats that had any lane clipped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat3_q    <= 1'b0;
      sat_cnt_q <= '0;
    end else begin
      if (ld3 && v2_q) sat3_q <= |(hi_c | lo_c);
      if (en && v3_q && bus.out_ready && sat3_q && (sat_cnt_q != 16'hFFFF))
        sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_act_unit_pipe.sv
// tb_act_unit_pipe: directed self-checking bench for act_unit_pipe (latency, modes, saturation, stalls, reset).
module tb_act_unit_pipe;
  localparam int unsigned DW = 26;
  localparam int unsigned FB = 9;
  localparam int unsigned OS = 14;
  localparam int unsigned LN = 16;
  localparam int          S  = 512;

  logic clk = 1'b0;
  logic rst;
  logic en;
`ifdef ACT_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  int checks = 0;
  int errors = 0;

  // hard-swish of x = (k-8)*512 for lanes k = 0..15, worked out by hand
  int exp00 [16] = '{0, 0, 0, 0, 0, 0, -170, -171, 0, 341, 854, 1536, 2048, 2560, 3072, 3584};

  act_unit_pipe_if #(.DATA_WIDTH(DW), .OUT_SIZE(OS), .LANES(LN)) bus ();

  act_unit_pipe #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .OUT_SIZE(OS), .LANES(LN)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
`ifdef ACT_SAT_CNT_EN
    .sat_count (sat_count),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [OS*LN-1:0] obs, input logic [OS*LN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] lane(input int k);
    return 64'($signed(bus.output_data[k*OS +: OS]));
  endfunction

  task automatic set_lane(input int k, input int v);
    bus.input_data[k*DW +: DW] = DW'(v);
  endtask

  function automatic logic [OS*LN-1:0] stream_vec(input int b);
    logic [OS*LN-1:0] v;
    v = '0;
    for (int k = 0; k < LN; k++) v[k*OS +: OS] = OS'(b*100 + k + 1);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  int               sent, rcvd;
  logic             stalled;
  logic [OS*LN-1:0] stall_data;

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.mode       = 2'b00;
    bus.input_data = '0;

    // reset state, before any clock edge
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_in_ready", 64'(bus.in_ready), 0);
    check_vec("rst_output_data", bus.output_data, '0);
`ifdef ACT_SAT_CNT_EN
    check("rst_sat_count", 64'(sat_count), 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("in_ready_after_rst", 64'(bus.in_ready), 1);

    // hard-swish across lanes -8..7, latency: valid after the third edge counting the accept edge
    for (int k = 0; k < LN; k++) set_lane(k, (k - 8) * S);
    bus.mode     = 2'b00;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("lat_edge1", 64'(bus.out_valid), 0);
    tick;
    check("lat_edge2", 64'(bus.out_valid), 0);
    tick;
    check("lat_edge3", 64'(bus.out_valid), 1);
    for (int k = 0; k < LN; k++) check($sformatf("hswish_lane%0d", k), lane(k), 64'(exp00[k]));
    tick;
    check("hswish_drained", 64'(bus.out_valid), 0);

    // saturation: x = 20S in hard-swish clips to 8191
    bus.input_data = '0;
    set_lane(0, 20 * S);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tick;
    tick;
    check("sat_valid", 64'(bus.out_valid), 1);
    check("sat_lane0", lane(0), 8191);
    check("sat_lane1", lane(1), 0);
`ifdef ACT_SAT_CNT_EN
    check("sat_count_before", 64'(sat_count), 0);
`endif
    tick;
`ifdef ACT_SAT_CNT_EN
    check("sat_count_after", 64'(sat_count), 1);
`endif
    check("sat_drained", 64'(bus.out_valid), 0);

    // back-to-back beats with modes 01, 10, 11 on x = -2S, S, 8S, 0
    bus.input_data = '0;
    set_lane(0, -2 * S);
    set_lane(1, S);
    set_lane(2, 8 * S);
    bus.mode     = 2'b01;
    bus.in_valid = 1'b1;
    #1;
    check("modes_in_ready", 64'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.mode = 2'b10;
    @(posedge clk);
    @(negedge clk);
    bus.mode = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("m01_valid", 64'(bus.out_valid), 1);
    check("m01_l0", lane(0), 85);
    check("m01_l1", lane(1), 341);
    check("m01_l2", lane(2), 512);
    check("m01_l3", lane(3), 256);
    tick;
    check("m10_valid", 64'(bus.out_valid), 1);
    check("m10_l0", lane(0), 0);
    check("m10_l1", lane(1), 512);
    check("m10_l2", lane(2), 4096);
    tick;
    check("m11_valid", 64'(bus.out_valid), 1);
    check("m11_l0", lane(0), 0);
    check("m11_l1", lane(1), 512);
    check("m11_l2", lane(2), 3072);
    tick;
    check("modes_drained", 64'(bus.out_valid), 0);

    // 10-beat ReLU stream, out_ready pattern 1,0,0,1 and en low for two cycles
    bus.mode = 2'b10;
    sent     = 0;
    rcvd     = 0;
    stalled  = 1'b0;
    stall_data = '0;
    for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
      en            = !(cyc == 6 || cyc == 7);
      bus.out_ready = en && ((cyc % 4) == 0 || (cyc % 4) == 3);
      bus.in_valid  = sent < 10;
      for (int k = 0; k < LN; k++) set_lane(k, sent*100 + k + 1);
      #1;
      if (stalled) begin
        check("stall_valid", 64'(bus.out_valid), 1);
        check_vec("stall_data", bus.output_data, stall_data);
      end
      if (bus.out_valid && bus.out_ready) begin
        check_vec($sformatf("stream_beat%0d", rcvd), bus.output_data, stream_vec(rcvd));
        rcvd++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      stalled    = bus.out_valid && !bus.out_ready;
      stall_data = bus.output_data;
      tick;
    end
    en            = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream_sent", 64'(sent), 10);
    check("stream_rcvd", 64'(rcvd), 10);
    tick;
    check("stream_no_extra", 64'(bus.out_valid), 0);

    // reset with three beats in flight
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < LN; k++) set_lane(k, 7000 + b);
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("inflight_valid", 64'(bus.out_valid), 1);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 0);
    check("midrst_in_ready", 64'(bus.in_ready), 0);
    check_vec("midrst_output_data", bus.output_data, '0);
`ifdef ACT_SAT_CNT_EN
    check("midrst_sat_count", 64'(sat_count), 0);
`endif
    tick;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("post_rst_idle%0d", i), 64'(bus.out_valid), 0);
    end
    for (int k = 0; k < LN; k++) set_lane(k, 1234);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("post_rst_lat1", 64'(bus.out_valid), 0);
    tick;
    check("post_rst_lat2", 64'(bus.out_valid), 0);
    tick;
    check("post_rst_lat3", 64'(bus.out_valid), 1);
    check("post_rst_l0", lane(0), 1234);
    check("post_rst_l15", lane(15), 1234);
    tick;
    check("post_rst_drained", 64'(bus.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
